// File: rtl/multitap_delay_line.sv
// ---------------------------------------------------------------------------
// multitap_delay_line
//   Multi-tap audio delay buffer. Each accepted sample is written into a
//   circular RAM and NUM_TAPS delayed copies are read back, one tap per cycle.
//   All taps are presented together with a single audio_valid_out pulse.
//
// Ports
//   clk_in          system clock
//   rst_in          synchronous reset, active-high
//   audio_valid_in  one-cycle strobe, audio_in holds a new sample
//   audio_in        input sample (WIDTH, signed, passed through untouched)
//   store_audio_in  1 = write sample into buffer, 0 = freeze (no write/advance)
//   delay_in        tap k delay at [k*AW +: AW], sampled on accept
//   ready_out       1 = next audio_valid_in will be accepted
//   audio_out       tap k delayed sample at [k*WIDTH +: WIDTH]
//   audio_valid_out one-cycle pulse, audio_out updated
//   overrun_out     sticky, a sample arrived while busy and was dropped
//   fill_out        samples stored since reset, saturating at DEPTH
// ---------------------------------------------------------------------------

// Per-tap address generation: clamp, circular subtract, bypass and fill mask.
module multitap_tap_calc #(
    parameter int DEPTH = 48000,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0] delay,
    input  logic [AW-1:0] wr_ptr,
    input  logic [AW:0]   fill,
    output logic [AW-1:0] addr,
    output logic          bypass,
    output logic          masked
);
    localparam logic [AW-1:0] DMAX = AW'(DEPTH - 1);

    logic [AW-1:0] d_cl;

    always_comb begin
        d_cl   = (delay > DMAX) ? DMAX : delay;
        // Wrap by adding DEPTH when the subtraction would go negative.
        if (wr_ptr >= d_cl)
            addr = wr_ptr - d_cl;
        else
            addr = AW'({1'b0, wr_ptr} + (AW+1)'(DEPTH) - {1'b0, d_cl});
        bypass = (d_cl == '0);
        masked = !bypass && ({1'b0, d_cl} > fill);
    end
endmodule

module multitap_delay_line #(
    parameter  int WIDTH    = 16,
    parameter  int DEPTH    = 48000,
    parameter  int NUM_TAPS = 4,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      audio_valid_in,
    input  logic [WIDTH-1:0]          audio_in,
    input  logic                      store_audio_in,
    input  logic [NUM_TAPS*AW-1:0]    delay_in,
    output logic                      ready_out,
    output logic [NUM_TAPS*WIDTH-1:0] audio_out,
    output logic                      audio_valid_out,
    output logic                      overrun_out,
    output logic [AW:0]               fill_out
);
    localparam int TW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT} state_t;

    state_t state_q, state_d;
    logic [TW-1:0] cnt_q;

    logic ready, issue, first_issue, accept;

    logic [AW-1:0] wr_ptr;
    logic [AW:0]   fill_q;
    logic          overrun_q;

    // Per-tap address/select computed from pre-accept pointer and fill.
    logic [AW-1:0] tap_addr   [NUM_TAPS];
    logic          tap_byp    [NUM_TAPS];
    logic          tap_msk    [NUM_TAPS];
    logic [AW-1:0] tap_addr_q [NUM_TAPS];
    logic          tap_byp_q  [NUM_TAPS];
    logic          tap_msk_q  [NUM_TAPS];

    logic [WIDTH-1:0] sample_q;
    logic             store_q;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_q1, rd_q2;

    // Read-return tracking, matches the 2-cycle RAM latency.
    logic [1:0]    rd_vld_pipe;
    logic [TW-1:0] rd_idx_pipe [2];

    logic [NUM_TAPS-1:0][WIDTH-1:0] shadow, out_q;

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        multitap_tap_calc #(.DEPTH(DEPTH), .AW(AW)) u_calc (
            .delay  (delay_in[k*AW +: AW]),
            .wr_ptr (wr_ptr),
            .fill   (fill_q),
            .addr   (tap_addr[k]),
            .bypass (tap_byp[k]),
            .masked (tap_msk[k])
        );
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            // cnt walks taps in ISSUE and the two DRAIN cycles; 0 on entry.
            if (state_d == state_q && (state_q == S_ISSUE || state_q == S_DRAIN))
                cnt_q <= cnt_q + TW'(1);
            else
                cnt_q <= '0;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_ISSUE;
            S_ISSUE: if (cnt_q == TW'(NUM_TAPS - 1)) state_d = S_DRAIN;
            S_DRAIN: if (cnt_q == TW'(1)) state_d = S_OUT;
            S_OUT:   state_d = accept ? S_ISSUE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ready           = (state_q == S_IDLE) || (state_q == S_OUT);
        audio_valid_out = (state_q == S_OUT);
        issue           = (state_q == S_ISSUE);
        first_issue     = issue && (cnt_q == '0);
    end

    assign accept    = audio_valid_in && ready;
    assign ready_out = ready;
    assign rd_addr   = tap_addr_q[cnt_q];

    // ---------------- control state with reset ----------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr      <= '0;
            fill_q      <= '0;
            overrun_q   <= 1'b0;
            rd_vld_pipe <= '0;
            out_q       <= '0;
        end else begin
            if (audio_valid_in && !ready)
                overrun_q <= 1'b1;
            if (first_issue && store_q) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
                if (fill_q != (AW+1)'(DEPTH))
                    fill_q <= fill_q + (AW+1)'(1);
            end
            rd_vld_pipe <= {rd_vld_pipe[0], issue};
            if (state_q == S_OUT)
                out_q <= shadow;
        end
    end

    // ---------------- datapath latches (no reset needed) ----------------
    always_ff @(posedge clk_in) begin
        if (accept) begin
            sample_q <= audio_in;
            store_q  <= store_audio_in;
            for (int k = 0; k < NUM_TAPS; k++) begin
                tap_addr_q[k] <= tap_addr[k];
                tap_byp_q[k]  <= tap_byp[k];
                tap_msk_q[k]  <= tap_msk[k];
            end
        end
        rd_idx_pipe[0] <= cnt_q;
        rd_idx_pipe[1] <= rd_idx_pipe[0];
        if (rd_vld_pipe[1]) begin
            if (tap_byp_q[rd_idx_pipe[1]])
                shadow[rd_idx_pipe[1]] <= sample_q;
            else if (tap_msk_q[rd_idx_pipe[1]])
                shadow[rd_idx_pipe[1]] <= '0;
            else
                shadow[rd_idx_pipe[1]] <= rd_q2;
        end
    end

    // ---------------- sample RAM: port A write, port B read ----------------
    always_ff @(posedge clk_in) begin
        if (first_issue && store_q)
            mem[wr_ptr] <= sample_q;
    end

    always_ff @(posedge clk_in) begin
        rd_q1 <= mem[rd_addr];
        rd_q2 <= rd_q1;
    end

    // Live shadow during OUT so data and valid appear together.
    assign audio_out   = (state_q == S_OUT) ? shadow : out_q;
    assign overrun_out = overrun_q;
    assign fill_out    = fill_q;

endmodule

// File: tb/tb_multitap_delay_line.sv
// Bench for multitap_delay_line. Main instance DEPTH=16, 3 taps; a second
// instance (DEPTH=12, 1 tap) exercises delay clamping, since a 4-bit delay
// field cannot hold a value above 15 for DEPTH=16.
module tb_multitap_delay_line;
    localparam int W  = 16;
    localparam int D  = 16;
    localparam int NT = 3;
    localparam int AW = 4;
    localparam int D2 = 12;

    logic clk = 1'b0, rst = 1'b1, vin = 1'b0, store = 1'b1;
    logic [W-1:0]     ain = '0;
    logic [NT*AW-1:0] dly_a = '0;
    logic [AW-1:0]    dly_b = '0;

    logic             rdy_a, vout_a, ovr_a;
    logic [NT*W-1:0]  aout_a;
    logic [AW:0]      fill_a;
    logic             rdy_b, vout_b, ovr_b;
    logic [W-1:0]     aout_b;
    logic [AW:0]      fill_b;

    multitap_delay_line #(.WIDTH(W), .DEPTH(D), .NUM_TAPS(NT)) dut (
        .clk_in(clk), .rst_in(rst), .audio_valid_in(vin), .audio_in(ain),
        .store_audio_in(store), .delay_in(dly_a), .ready_out(rdy_a),
        .audio_out(aout_a), .audio_valid_out(vout_a), .overrun_out(ovr_a),
        .fill_out(fill_a));

    multitap_delay_line #(.WIDTH(W), .DEPTH(D2), .NUM_TAPS(1)) dut_b (
        .clk_in(clk), .rst_in(rst), .audio_valid_in(vin), .audio_in(ain),
        .store_audio_in(store), .delay_in(dly_b), .ready_out(rdy_b),
        .audio_out(aout_b), .audio_valid_out(vout_b), .overrun_out(ovr_b),
        .fill_out(fill_b));

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] data;
        int          due;
    } exp_t;

    exp_t qa[$], qb[$];
    int   hist[$];
    int   da[NT];
    int   db = 0;
    int   total = 0, bad = 0, cyc = 0, pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference model: stored-sample history, fill = min(stored, depth).
    function automatic int tap_exp(int s, int d, int depth);
        int dc, fl;
        dc = (d > depth - 1) ? depth - 1 : d;
        fl = (hist.size() < depth) ? hist.size() : depth;
        if (dc == 0) return s;
        if (dc > fl) return 0;
        return hist[hist.size() - dc];
    endfunction

    task automatic set_delays(input int d0, input int d1, input int d2, input int dbb);
        da[0] = d0; da[1] = d1; da[2] = d2; db = dbb;
        for (int k = 0; k < NT; k++) dly_a[k*AW +: AW] = da[k][AW-1:0];
        dly_b = db[AW-1:0];
    endtask

    // Entered and left at a negedge; the strobe is held for one cycle.
    task automatic send(input int s, input logic st);
        int   n, t;
        exp_t e;
        n = 0;
        while (!rdy_a && n < 50) begin @(negedge clk); n++; end
        chk("send_ready", {46'd0, rdy_a, rdy_b}, 48'd3);
        vin = 1'b1; ain = s[W-1:0]; store = st;
        e.data = '0;
        for (int k = 0; k < NT; k++) begin
            t = tap_exp(s, da[k], D);
            e.data[k*W +: W] = t[W-1:0];
        end
        e.due = cyc + NT + 3;
        qa.push_back(e);
        t = tap_exp(s, db, D2);
        e.data = {32'd0, t[W-1:0]};
        e.due = cyc + 4;
        qb.push_back(e);
        if (st) hist.push_back(s);
        @(negedge clk);
        vin = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((qa.size() > 0 || qb.size() > 0) && n < 200) begin @(negedge clk); n++; end
        chk("drain_timeout", qa.size() + qb.size(), 0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        qa.delete(); qb.delete(); hist.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Scoreboard: pop and compare on each valid pulse; flag missing pulses.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (vout_a) begin
                pulses++;
                chk("a_pending", qa.size() > 0, 1);
                if (qa.size() > 0) begin
                    e = qa.pop_front();
                    chk("a_latency", cyc, e.due);
                    chk("a_data", aout_a, e.data);
                end
            end else if (qa.size() > 0 && cyc >= qa[0].due) begin
                chk("a_valid_at_due", vout_a, 1);
                void'(qa.pop_front());
            end
            if (vout_b) begin
                chk("b_pending", qb.size() > 0, 1);
                if (qb.size() > 0) begin
                    e = qb.pop_front();
                    chk("b_latency", cyc, e.due);
                    chk("b_data", aout_b, e.data);
                end
            end else if (qb.size() > 0 && cyc >= qb[0].due) begin
                chk("b_valid_at_due", vout_b, 1);
                void'(qb.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        do_reset();
        chk("rst_ready", rdy_a, 1);
        chk("rst_valid", vout_a, 0);
        chk("rst_aout", aout_a, 0);
        chk("rst_overrun", ovr_a, 0);
        chk("rst_fill", fill_a, 0);

        // T1: basic taps, back-to-back accepts in the OUT cycle
        set_delays(0, 1, 3, 15);
        for (int n = 1; n <= 10; n++) send(n, 1'b1);
        wait_idle();
        chk("t1_last", aout_a, {16'd0, 16'd7, 16'd9, 16'd10});

        // T2: fill mask right after reset
        do_reset();
        set_delays(0, 2, 5, 15);
        send(100, 1'b1); send(200, 1'b1); send(300, 1'b1);
        wait_idle();
        chk("t2_last", aout_a, {16'd0, 16'd0, 16'd100, 16'd300});

        // T3: wrap; clamp checked on the DEPTH=12 instance (15 -> 11)
        do_reset();
        set_delays(15, 15, 1, 15);
        for (int n = 1; n <= 40; n++) send(n, 1'b1);
        wait_idle();
        chk("t3_out", aout_a, {16'd0, 16'd39, 16'd25, 16'd25});
        chk("t3_fill", fill_a, 16);
        chk("t3_clamp_out", aout_b, 29);
        chk("t3_clamp_fill", fill_b, 12);

        // T4: freeze
        do_reset();
        set_delays(1, 0, 3, 15);
        for (int n = 1; n <= 5; n++) send(n, 1'b1);
        send(77, 1'b0);
        wait_idle();
        chk("t4_frozen_tap", aout_a[15:0], 5);
        chk("t4_frozen_bypass", aout_a[31:16], 77);
        chk("t4_frozen_fill", fill_a, 5);
        send(6, 1'b1);
        wait_idle();
        chk("t4_after_tap", aout_a[15:0], 5);
        chk("t4_after_fill", fill_a, 6);

        // T5: overrun two cycles after an accept
        do_reset();
        set_delays(0, 1, 2, 1);
        pulses = 0;
        send(1, 1'b1);
        @(negedge clk);
        vin = 1'b1; ain = 16'd999;
        @(negedge clk);
        vin = 1'b0;
        chk("t5_overrun", ovr_a, 1);
        chk("t5_overrun_b", ovr_b, 1);
        wait_idle();
        chk("t5_pulses", pulses, 1);
        send(2, 1'b1);
        wait_idle();
        chk("t5_sticky", ovr_a, 1);
        do_reset();
        chk("t5_cleared", ovr_a, 0);

        // T6: reset during ISSUE aborts the sample
        set_delays(0, 1, 2, 1);
        send(3, 1'b1);
        wait_idle();
        pulses = 0;
        send(5, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        qa.delete(); qb.delete(); hist.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("t6_ready", rdy_a, 1);
        chk("t6_aout", aout_a, 0);
        chk("t6_fill", fill_a, 0);
        chk("t6_valid", vout_a, 0);
        repeat (12) @(negedge clk);
        chk("t6_no_pulse", pulses, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
